wb_req_master: RTL and testbench
================================

Name: wb_req_master

Overview:
Wishbone classic-cycle initiator. Converts a simple valid/ready request/response interface into single Wishbone read/write cycles. Handles ack/err/rty termination, bounded retry and a timeout watchdog. Sits in front of any Wishbone responder path, e.g. the master side of the clock-domain bridge, so CPU-side or DMA-side logic can issue bus transactions without Wishbone timing knowledge.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8/16/32/64)
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte select width
TIMEOUT, 255, max cycles stb may stay high without termination; 0 disables the watchdog
MAX_RETRY, 3, number of reissues allowed after rty before reporting failure

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_we  in  1  1=write, 0=read
req_sel  in  SELECT_WIDTH  byte selects
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and failures)
rsp_status  out  2  00 OK, 01 ERR, 10 RTY exhausted, 11 TIMEOUT
busy  out  1  high in any state other than IDLE
wbm_adr_o  out  ADDR_WIDTH  Wishbone address
wbm_dat_o  out  DATA_WIDTH  Wishbone write data
wbm_dat_i  in  DATA_WIDTH  Wishbone read data
wbm_we_o  out  1  write enable
wbm_sel_o  out  SELECT_WIDTH  byte select
wbm_stb_o  out  1  strobe
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  error
wbm_rty_i  in  1  retry
wbm_cyc_o  out  1  cycle

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE. All Wishbone outputs, rsp_valid, rsp_rdata, rsp_status and busy are 0. Retry and timeout counters are 0. A reset mid-cycle drops cyc/stb immediately, without waiting for a clock edge.
- Every output is registered. req_ready = (state==IDLE).
- IDLE: on the edge where req_valid && req_ready, capture addr/wdata/we/sel into the Wishbone output regs, set cyc=stb=1, clear the retry counter, and go to CYCLE. Accept-to-cyc latency is 1 edge.
- CYCLE: adr/dat/we/sel/cyc/stb are held stable. The timeout counter increments each cycle with no termination seen.
  - Termination priority when several are asserted in the same cycle: err > ack > rty.
  - ack: rsp_rdata = we ? 0 : wbm_dat_i; status 00; cyc=stb=0 at the same edge; go to RESP.
  - err: rsp_rdata = 0; status 01; drop cyc/stb; go to RESP.
  - rty with retry_cnt < MAX_RETRY: retry_cnt++, drop cyc/stb, go to GAP.
  - rty with retry_cnt == MAX_RETRY: status 10, rdata 0; go to RESP.
  - TIMEOUT != 0 and counter reaches TIMEOUT with no termination: drop cyc/stb; status 11, rdata 0; go to RESP. A termination arriving in that same cycle takes precedence over the timeout.
- GAP: exactly 1 cycle with cyc=stb=0 and request fields held. Timeout counter cleared. Then re-raise cyc/stb and return to CYCLE.
- RESP: rsp_valid=1, and rdata/status are held until rsp_ready. On the edge where rsp_valid && rsp_ready: clear rsp_valid and go to IDLE. There is no same-cycle reaccept, so cyc stays low for at least 2 cycles between transactions. This is required for responders that edge-detect stb.
- ack/err/rty seen outside CYCLE are ignored.
- Timeout counter width is clog2(TIMEOUT+1), saturating; it never wraps.
- req_* inputs are sampled only at the accept edge. Later changes have no effect on the current transaction.

Test Plan:
- Write addr=0x0000_0010, wdata=0xDEAD_BEEF, sel=0xF; responder acks on the 3rd stb cycle -> cyc/stb high 1 edge after accept, adr/dat/sel stable throughout, rsp_valid with status 00 and rdata 0; cyc low ≥2 cycles before the next transaction.
- Read addr 0x20, responder returns 0x1234_5678 with ack after 0 wait states, while rsp_ready is held low 5 cycles -> rsp_rdata=0x1234_5678 and status 00 held stable until the rsp_ready edge; req_ready low until then.
- Responder asserts rty twice then ack -> exactly two 1-cycle GAPs with cyc=0, three cyc pulses total, status 00. A second run with rty 4 times (MAX_RETRY=3) -> 4 cyc pulses, status 10.
- err and ack asserted together -> status 01, rdata 0. A silent responder with TIMEOUT=8 -> stb high exactly 8 cycles, then status 11.
- rst_n pulled low mid-CYCLE (asynchronously, between edges) -> cyc/stb/rsp_valid go 0 immediately; after release the state is IDLE with req_ready=1 and a fresh request completes normally.

Source files
------------

// File: rtl/wb_req_master.sv
// Wishbone classic-cycle initiator: turns one valid/ready request into a single
// read or write cycle, with bounded retry on rty and a stalled-stb watchdog.
module wb_req_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255,
  parameter int MAX_RETRY    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    req_we,
  input  logic [SELECT_WIDTH-1:0] req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_status,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  output logic                    wbm_cyc_o
);

  // Counter widths are kept at least one bit so TIMEOUT=0 / MAX_RETRY=0 still elaborate.
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TO_W-1:0] TO_SAT  = {TO_W{1'b1}};
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    GAP   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   adr_r, adr_s;
  logic [DATA_WIDTH-1:0]   dat_r, dat_s;
  logic                    we_r, we_s;
  logic [SELECT_WIDTH-1:0] sel_r, sel_s;
  logic                    cyc_r, cyc_s;
  logic                    stb_r, stb_s;
  logic                    rsp_valid_r, rsp_valid_s;
  logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
  logic [1:0]              status_r, status_s;
  logic                    req_ready_r, req_ready_s;
  logic                    busy_r, busy_s;
  logic [RT_W-1:0]         retry_r, retry_s;
  logic [TO_W-1:0]         to_cnt_r, to_cnt_s;
  logic                    to_hit_s;

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    state_s     = state_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    we_s        = we_r;
    sel_s       = sel_r;
    cyc_s       = cyc_r;
    stb_s       = stb_r;
    rsp_valid_s = rsp_valid_r;
    rdata_s     = rdata_r;
    status_s    = status_r;
    retry_s     = retry_r;
    to_cnt_s    = to_cnt_r;
    to_hit_s    = (TIMEOUT != 0) && (to_cnt_r == TO_LAST);

    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          adr_s    = req_addr;
          dat_s    = req_wdata;
          we_s     = req_we;
          sel_s    = req_sel;
          cyc_s    = 1'b1;
          stb_s    = 1'b1;
          retry_s  = '0;
          to_cnt_s = '0;
          state_s  = CYCLE;
        end else begin
          state_s  = IDLE;
        end
      end

      // Terminations are checked before the watchdog so a late ack still wins.
      CYCLE: begin
        if (wbm_err_i) begin
          rdata_s     = '0;
          status_s    = ST_ERR;
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else if (wbm_ack_i) begin
          rdata_s     = we_r ? '0 : wbm_dat_i;
          status_s    = ST_OK;
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else if (wbm_rty_i) begin
          cyc_s = 1'b0;
          stb_s = 1'b0;
          if (retry_r < RT_MAX) begin
            retry_s = retry_r + 1'b1;
            state_s = GAP;
          end else begin
            rdata_s     = '0;
            status_s    = ST_RTY;
            rsp_valid_s = 1'b1;
            state_s     = RESP;
          end
        end else if (to_hit_s) begin
          to_cnt_s    = to_cnt_r + 1'b1;
          rdata_s     = '0;
          status_s    = ST_TO;
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else begin
          to_cnt_s = (to_cnt_r == TO_SAT) ? to_cnt_r : to_cnt_r + 1'b1;
          state_s  = CYCLE;
        end
      end

      GAP: begin
        to_cnt_s = '0;
        cyc_s    = 1'b1;
        stb_s    = 1'b1;
        state_s  = CYCLE;
      end

      // Leaving via IDLE guarantees cyc low for at least two cycles between transactions.
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s     = RESP;
        end
      end

      default: begin
        cyc_s       = 1'b0;
        stb_s       = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase

    req_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
  end

  // State and output registers; reset drops the bus cycle without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      adr_r       <= '0;
      dat_r       <= '0;
      we_r        <= 1'b0;
      sel_r       <= '0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= '0;
      status_r    <= 2'b00;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      retry_r     <= '0;
      to_cnt_r    <= '0;
    end else begin
      state_r     <= state_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      rsp_valid_r <= rsp_valid_s;
      rdata_r     <= rdata_s;
      status_r    <= status_s;
      req_ready_r <= req_ready_s;
      busy_r      <= busy_s;
      retry_r     <= retry_s;
      to_cnt_r    <= to_cnt_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rdata_r;
  assign rsp_status = status_r;
  assign busy       = busy_r;
  assign wbm_adr_o  = adr_r;
  assign wbm_dat_o  = dat_r;
  assign wbm_we_o   = we_r;
  assign wbm_sel_o  = sel_r;
  assign wbm_stb_o  = stb_r;
  assign wbm_cyc_o  = cyc_r;

endmodule

// File: tb/tb_wb_req_master.sv
// Bench for wb_req_master: scripted Wishbone responder, response scoreboard
// checked at every rsp handshake, plus per-scenario timing checks.
module tb_wb_req_master;

  localparam int T_ACK    = 0;
  localparam int T_ERR    = 1;
  localparam int T_BOTH   = 2;
  localparam int T_SILENT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_we = 1'b0;
  logic [3:0]  req_sel = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_rty_i = 1'b0;
  logic        wbm_cyc_o;

  int total = 0;
  int bad = 0;
  logic [33:0] sb[$];
  logic [31:0] exp_adr, exp_dat;
  logic        exp_we;
  logic [3:0]  exp_sel;
  int pulses = 0, low_run = 0, last_low = 0;
  logic cyc_prev = 1'b0;
  int stb_cycles, gap_cycles, unstable;
  logic rsp_seen;

  wb_req_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(8), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .busy(busy),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_cyc_o(wbm_cyc_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge once inputs for the coming posedge are set.
  task automatic tick();
    logic [33:0] e;
    if (rsp_valid && rsp_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got status=%b rdata=%h, expected no response", rsp_status, rsp_rdata);
      end else begin
        e = sb.pop_front();
        if (rsp_status !== e[33:32] || rsp_rdata !== e[31:0]) begin
          bad++;
          $display("FAIL scoreboard: got status=%b rdata=%h, expected status=%b rdata=%h",
                   rsp_status, rsp_rdata, e[33:32], e[31:0]);
        end
      end
    end
    if (wbm_cyc_o && !cyc_prev) begin
      pulses++;
      last_low = low_run;
    end
    low_run  = wbm_cyc_o ? 0 : low_run + 1;
    cyc_prev = wbm_cyc_o;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [3:0] s, input logic [1:0] est, input logic [31:0] erd);
    sb.push_back({est, erd});
    exp_adr = a; exp_dat = d; exp_we = we; exp_sel = s;
    req_addr = a; req_wdata = d; req_we = we; req_sel = s; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_we = ~we; req_sel = ~s;
  endtask

  // Responder: n_rty retries, each pulse terminated after `waits` idle stb cycles.
  task automatic serve(input int n_rty, input int waits, input int term, input logic [31:0] data);
    int w = 0;
    int rtys = 0;
    stb_cycles = 0; gap_cycles = 0; unstable = 0; rsp_seen = 1'b0;
    for (int g = 0; g < 64; g++) begin
      if (rsp_valid) begin
        rsp_seen = 1'b1;
        break;
      end
      if (wbm_cyc_o) begin
        stb_cycles++;
        if (!wbm_stb_o || wbm_adr_o !== exp_adr || wbm_dat_o !== exp_dat ||
            wbm_we_o !== exp_we || wbm_sel_o !== exp_sel) unstable++;
        if (term != T_SILENT && w == waits) begin
          w = 0;
          if (rtys < n_rty) begin
            wbm_rty_i = 1'b1;
            rtys++;
          end else begin
            wbm_dat_i = data;
            wbm_ack_i = (term == T_ACK || term == T_BOTH);
            wbm_err_i = (term == T_ERR || term == T_BOTH);
          end
        end else begin
          w++;
        end
      end else begin
        gap_cycles++;
      end
      tick();
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = 32'hA5A5_5A5A;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, req_ready} !== 5'b00001 ||
        rsp_status !== 2'b00 || rsp_rdata !== 32'h0 || wbm_adr_o !== 32'h0) begin
      bad++;
      $display("FAIL reset: got cyc/stb/rsp_valid/busy/req_ready=%b%b%b%b%b status=%b, expected 00001 status=00",
               wbm_cyc_o, wbm_stb_o, rsp_valid, busy, req_ready, rsp_status);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    pulses = 0;
    issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 2'b00, 32'h0);
    total++;
    if ({wbm_cyc_o, wbm_stb_o, busy, req_ready} !== 4'b1110) begin
      bad++;
      $display("FAIL write_latency: got cyc/stb/busy/req_ready=%b%b%b%b, expected 1110",
               wbm_cyc_o, wbm_stb_o, busy, req_ready);
    end
    serve(0, 2, T_ACK, 32'hFFFF_0000);
    total++;
    if (!rsp_seen || stb_cycles != 3 || unstable != 0 || pulses != 1) begin
      bad++;
      $display("FAIL write_cycle: got rsp=%0d stb_cycles=%0d unstable=%0d pulses=%0d, expected 1 3 0 1",
               rsp_seen, stb_cycles, unstable, pulses);
    end
    consume();
    total++;
    if ({rsp_valid, req_ready, busy, wbm_cyc_o} !== 4'b0100) begin
      bad++;
      $display("FAIL write_release: got rsp_valid/req_ready/busy/cyc=%b%b%b%b, expected 0100",
               rsp_valid, req_ready, busy, wbm_cyc_o);
    end
  endtask

  task automatic test_read_hold();
    issue(32'h0000_0020, 32'h0, 1'b0, 4'hF, 2'b00, 32'h1234_5678);
    serve(0, 0, T_ACK, 32'h1234_5678);
    total++;
    if (!rsp_seen || stb_cycles != 1) begin
      bad++;
      $display("FAIL read_zero_wait: got rsp=%0d stb_cycles=%0d, expected 1 1", rsp_seen, stb_cycles);
    end
    // Stray terminations while waiting on rsp_ready must be ignored.
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 32'h1234_5678 ||
          req_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
        bad++;
        $display("FAIL read_hold[%0d]: got valid=%b status=%b rdata=%h req_ready=%b cyc=%b, expected 1 00 12345678 0 0",
                 i, rsp_valid, rsp_status, rsp_rdata, req_ready, wbm_cyc_o);
      end
      wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_rty_i = 1'b1;
      tick();
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    consume();
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0040, 32'h0BAD_F00D, 1'b1, 4'h3, 2'b00, 32'h0);
    serve(0, 1, T_ACK, 32'h7777_7777);
    consume();
    issue(32'h0000_0044, 32'h0, 1'b0, 4'hC, 2'b00, 32'h8765_4321);
    serve(0, 0, T_ACK, 32'h8765_4321);
    total++;
    if (!rsp_seen || last_low < 2) begin
      bad++;
      $display("FAIL back_to_back_gap: got rsp=%0d cyc_low_cycles=%0d, expected 1 and >=2", rsp_seen, last_low);
    end
    consume();
  endtask

  task automatic test_retry();
    pulses = 0;
    issue(32'h0000_0080, 32'h0, 1'b0, 4'hF, 2'b00, 32'hCAFE_F00D);
    serve(2, 0, T_ACK, 32'hCAFE_F00D);
    total++;
    if (!rsp_seen || pulses != 3 || gap_cycles != 2 || stb_cycles != 3 || unstable != 0) begin
      bad++;
      $display("FAIL retry_two: got rsp=%0d pulses=%0d gaps=%0d stb=%0d unstable=%0d, expected 1 3 2 3 0",
               rsp_seen, pulses, gap_cycles, stb_cycles, unstable);
    end
    consume();
    pulses = 0;
    issue(32'h0000_0084, 32'h5555_AAAA, 1'b1, 4'hF, 2'b10, 32'h0);
    serve(4, 0, T_ACK, 32'h1);
    total++;
    if (!rsp_seen || pulses != 4 || gap_cycles != 3) begin
      bad++;
      $display("FAIL retry_exhaust: got rsp=%0d pulses=%0d gaps=%0d, expected 1 4 3", rsp_seen, pulses, gap_cycles);
    end
    consume();
  endtask

  task automatic test_err_timeout();
    issue(32'h0000_00C0, 32'h0, 1'b0, 4'hF, 2'b01, 32'h0);
    serve(0, 1, T_BOTH, 32'h1111_2222);
    total++;
    if (!rsp_seen || stb_cycles != 2) begin
      bad++;
      $display("FAIL err_ack: got rsp=%0d stb_cycles=%0d, expected 1 2", rsp_seen, stb_cycles);
    end
    consume();
    issue(32'h0000_00C4, 32'h0, 1'b0, 4'hF, 2'b11, 32'h0);
    serve(0, 0, T_SILENT, 32'h0);
    total++;
    if (!rsp_seen || stb_cycles != 8) begin
      bad++;
      $display("FAIL timeout: got rsp=%0d stb_cycles=%0d, expected 1 8", rsp_seen, stb_cycles);
    end
    consume();
    // Ack in the very cycle the watchdog expires still completes normally.
    issue(32'h0000_00C8, 32'h0, 1'b0, 4'hF, 2'b00, 32'h3333_4444);
    serve(0, 7, T_ACK, 32'h3333_4444);
    total++;
    if (!rsp_seen || stb_cycles != 8) begin
      bad++;
      $display("FAIL ack_at_timeout: got rsp=%0d stb_cycles=%0d, expected 1 8", rsp_seen, stb_cycles);
    end
    consume();
  endtask

  task automatic test_async_reset();
    logic [33:0] drop;
    issue(32'h0000_0100, 32'h0, 1'b0, 4'hF, 2'b00, 32'h0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, req_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL async_reset: got cyc/stb/rsp_valid/busy/req_ready=%b%b%b%b%b, expected 00001",
               wbm_cyc_o, wbm_stb_o, rsp_valid, busy, req_ready);
    end
    drop = sb.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulses = 0;
    issue(32'h0000_0104, 32'h0, 1'b0, 4'h1, 2'b00, 32'h9999_0001);
    serve(0, 1, T_ACK, 32'h9999_0001);
    total++;
    if (!rsp_seen || pulses != 1 || stb_cycles != 2) begin
      bad++;
      $display("FAIL after_reset: got rsp=%0d pulses=%0d stb=%0d, expected 1 1 2 (dropped %h)",
               rsp_seen, pulses, stb_cycles, drop);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_back_to_back();
    test_retry();
    test_err_timeout();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending responses, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
